ex_mem_loader: RTL and testbench

EX_MEM_LOADER -- requirements
Module: ex_mem_loader

---
 rtl/ex_mem_loader.sv | 146 ++++++++++++++
 tb/tb_ex_mem_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_loader.sv
// Host byte-stream loader: 'L' frames write 16-byte records into the core's external-memory ports, 'G' releases cpu_reset.
// Define LOADER_CHECKSUM_EN to append and verify a trailing XOR checksum byte on every load frame.
module ex_mem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        enable_load_ex_mem,
    output logic [8:0]  InstExMemAddress,
    output logic [31:0] InstExMemData1,
    output logic [31:0] InstExMemData2,
    output logic [8:0]  DataExMemAddress,
    output logic [31:0] DataExMemData1,
    output logic [31:0] DataExMemData2,
    output logic        cpu_reset,
    output logic        err
);

    localparam int unsigned ByteW    = 8;
    localparam int unsigned AddrW    = 9;
    localparam int unsigned IdxW     = 4;
    localparam int unsigned PartialW = 15 * ByteW;
    localparam logic [ByteW-1:0] CmdLoad = 8'h4C;
    localparam logic [ByteW-1:0] CmdGo   = 8'h47;

    typedef enum logic [2:0] {
        Idle,
        Count,
        Rec,
        Write,
`ifdef LOADER_CHECKSUM_EN
        Csum,
`endif
        Run
    } state_t;

    state_t              state;
    logic [IdxW-1:0]     byteIdx;
    logic [ByteW-1:0]    recsLeft;
    logic [PartialW-1:0] recShift;
`ifdef LOADER_CHECKSUM_EN
    logic [ByteW-1:0]    csumAcc;
`endif

    logic accept;
    assign accept = in_valid && in_ready;

    // Both ports share one word-pair address.
    assign DataExMemAddress = InstExMemAddress;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= Idle;
            in_ready           <= 1'b0;
            enable_load_ex_mem <= 1'b0;
            InstExMemAddress   <= '0;
            InstExMemData1     <= '0;
            InstExMemData2     <= '0;
            DataExMemData1     <= '0;
            DataExMemData2     <= '0;
            cpu_reset          <= 1'b1;
            err                <= 1'b0;
            byteIdx            <= '0;
            recsLeft           <= '0;
            recShift           <= '0;
`ifdef LOADER_CHECKSUM_EN
            csumAcc            <= '0;
`endif
        end else begin
            enable_load_ex_mem <= 1'b0;
            in_ready           <= 1'b1;

            if (accept) begin
                case (state)
                    Idle, Run: begin
                        if (in_data == CmdLoad) begin
                            state            <= Count;
                            InstExMemAddress <= '0;
                            cpu_reset        <= 1'b1;
                            err              <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                            csumAcc          <= '0;
`endif
                        end else if (in_data == CmdGo) begin
                            // 'G' only releases the core from a clean IDLE.
                            if (state == Idle && !err) begin
                                cpu_reset <= 1'b0;
                                state     <= Run;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    Count: begin
                        recsLeft <= in_data;
                        byteIdx  <= '0;
                        state    <= Rec;
                    end
                    Rec: begin
                        byteIdx  <= byteIdx + IdxW'(1);
                        recShift <= {in_data, recShift[PartialW-1:ByteW]};
`ifdef LOADER_CHECKSUM_EN
                        csumAcc  <= csumAcc ^ in_data;
`endif
                        // Last byte arrives live; earlier 15 sit little-endian in recShift.
                        if (byteIdx == IdxW'(15)) begin
                            InstExMemData1     <= recShift[31:0];
                            InstExMemData2     <= recShift[63:32];
                            DataExMemData1     <= recShift[95:64];
                            DataExMemData2     <= {in_data, recShift[119:96]};
                            enable_load_ex_mem <= 1'b1;
                            in_ready           <= 1'b0;
                            state              <= Write;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    Csum: begin
                        if (in_data != csumAcc) begin
                            err <= 1'b1;
                        end
                        state <= Idle;
                    end
`endif
                    default: ;
                endcase
            end

            // Count byte 0 wraps through 255 so it yields 256 records.
            if (state == Write) begin
                InstExMemAddress <= InstExMemAddress + AddrW'(2);
                recsLeft         <= recsLeft - ByteW'(1);
                if (recsLeft == ByteW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state <= Csum;
`else
                    state <= Idle;
`endif
                end else begin
                    state <= Rec;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_loader.sv
// Randomized self-checking bench for ex_mem_loader; expected record writes come from a frame-level model.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_ex_mem_loader;

    logic        tb_clk = 1'b0;
    logic        reset;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady;
    logic        enableLoad;
    logic [8:0]  instAddr;
    logic [31:0] instData1;
    logic [31:0] instData2;
    logic [8:0]  dataAddr;
    logic [31:0] dataData1;
    logic [31:0] dataData2;
    logic        cpuReset;
    logic        err;

    int checks = 0;
    int failures = 0;
    int strobeCount = 0;
    bit useGaps = 1'b0;

    // Record image as {DataData2, DataData1, InstData2, InstData1}; byte j of the record is bits 8j+7:8j.
    logic [127:0] recs [256];

    always #5 tb_clk = ~tb_clk;

    ex_mem_loader dut (
        .clk                (tb_clk),
        .reset              (reset),
        .in_data            (inData),
        .in_valid           (inValid),
        .in_ready           (inReady),
        .enable_load_ex_mem (enableLoad),
        .InstExMemAddress   (instAddr),
        .InstExMemData1     (instData1),
        .InstExMemData2     (instData2),
        .DataExMemAddress   (dataAddr),
        .DataExMemData1     (dataData1),
        .DataExMemData2     (dataData2),
        .cpu_reset          (cpuReset),
        .err                (err)
    );

    always @(posedge tb_clk) begin
        if (enableLoad) strobeCount <= strobeCount + 1;
    end

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte (after optional random idle gaps) and return #1 after the accepting edge.
    task automatic sendByte(input logic [7:0] b);
        int guard = 0;
        if (useGaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge tb_clk);
                inValid = 1'b0;
                inData  = 8'($urandom);
            end
        end
        @(negedge tb_clk);
        inData  = b;
        inValid = 1'b1;
        while (!inReady && guard < 200) begin
            @(negedge tb_clk);
            guard++;
        end
        if (guard >= 200) begin
            checkVal("ready_timeout", 128'(0), 128'(1));
        end
        @(posedge tb_clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic loadFrame(input int n, input bit badCsum);
        int cnt = (n == 0) ? 256 : n;
        int startStrobes;
        logic [7:0] csum = 8'h00;
        logic [7:0] b;
        logic [8:0] expAddr = 9'd0;
        startStrobes = strobeCount;
        sendByte(8'h4C);
        checkVal("load_cpu_reset", 128'(cpuReset), 128'(1));
        checkVal("load_err_clear", 128'(err), 128'(0));
        sendByte(8'(n));
        for (int i = 0; i < cnt; i++) begin
            for (int j = 0; j < 16; j++) begin
                b = recs[i][8*j +: 8];
                csum ^= b;
                sendByte(b);
            end
            @(negedge tb_clk);
            checkVal("strobe_on", 128'(enableLoad), 128'(1));
            checkVal("strobe_inst_addr", 128'(instAddr), 128'(expAddr));
            checkVal("strobe_data_addr", 128'(dataAddr), 128'(expAddr));
            checkVal("strobe_ready_low", 128'(inReady), 128'(0));
            checkVal("strobe_data", {dataData2, dataData1, instData2, instData1}, recs[i]);
            expAddr += 9'd2;
        end
`ifdef LOADER_CHECKSUM_EN
        sendByte(badCsum ? ~csum : csum);
`endif
        @(negedge tb_clk);
        checkVal("frame_strobes", 128'(strobeCount - startStrobes), 128'(cnt));
        checkVal("frame_addr_end", 128'(instAddr), 128'(expAddr));
        checkVal("frame_strobe_off", 128'(enableLoad), 128'(0));
        checkVal("frame_err", 128'(err), 128'(badCsum));
        checkVal("frame_cpu_reset", 128'(cpuReset), 128'(1));
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "_ready"}, 128'(inReady), 128'(0));
        checkVal({tag, "_strobe"}, 128'(enableLoad), 128'(0));
        checkVal({tag, "_addr"}, 128'({instAddr, dataAddr}), 128'(0));
        checkVal({tag, "_data"}, {dataData2, dataData1, instData2, instData1}, 128'(0));
        checkVal({tag, "_cpu_reset"}, 128'(cpuReset), 128'(1));
        checkVal({tag, "_err"}, 128'(err), 128'(0));
    endtask

    task automatic randomRecs(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            recs[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    initial begin
        int snap;
        reset   = 1'b1;
        inValid = 1'b0;
        inData  = 8'h00;
        repeat (3) @(negedge tb_clk);
        checkResetState("por");
        reset = 1'b0;
        repeat (2) @(negedge tb_clk);
        checkVal("ready_after_reset", 128'(inReady), 128'(1));

        // Directed single record, then release the core.
        recs[0] = {32'h000000FF, 32'h00008F00, 32'h00038303, 32'h00100393};
        loadFrame(1, 1'b0);
        sendByte(8'h47);
        checkVal("go_cpu_reset", 128'(cpuReset), 128'(0));

        // Bad byte in RUN flags err but leaves the core running; 'G' is a no-op there.
        sendByte(8'h33);
        checkVal("run_bad_err", 128'(err), 128'(1));
        checkVal("run_bad_cpu_reset", 128'(cpuReset), 128'(0));
        sendByte(8'h47);
        checkVal("run_go_cpu_reset", 128'(cpuReset), 128'(0));

        // Three records with random in_valid gaps, started from RUN.
        useGaps = 1'b1;
        randomRecs(3);
        loadFrame(3, 1'b0);
        useGaps = 1'b0;

        // Unknown command in IDLE blocks 'G' until the next 'L'.
        sendByte(8'h55);
        checkVal("idle_bad_err", 128'(err), 128'(1));
        sendByte(8'h47);
        checkVal("go_blocked_cpu_reset", 128'(cpuReset), 128'(1));
        randomRecs(1);
        loadFrame(1, 1'b0);
        repeat (5) @(negedge tb_clk);
        checkVal("hold_data", {dataData2, dataData1, instData2, instData1}, recs[0]);

        // Reset after 9 bytes of a record.
        snap = strobeCount;
        sendByte(8'h4C);
        sendByte(8'd2);
        for (int j = 0; j < 9; j++) sendByte(8'($urandom));
        @(negedge tb_clk);
        reset = 1'b1;
        @(negedge tb_clk);
        checkResetState("mid_reset");
        reset = 1'b0;
        repeat (4) @(negedge tb_clk);
        checkVal("mid_reset_no_strobe", 128'(strobeCount - snap), 128'(0));
        randomRecs(2);
        loadFrame(2, 1'b0);

        // Full 256-record frame: last write at 510, address wraps to 0.
        randomRecs(256);
        loadFrame(0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        randomRecs(1);
        loadFrame(1, 1'b1);
        sendByte(8'h47);
        checkVal("csum_go_blocked", 128'(cpuReset), 128'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
